// File: rtl/morse_char_decoder.sv
// morse_char_decoder: buffers dot/dash pulses and emits the ITU Morse ASCII character on each gap.
module morse_char_decoder #(
    parameter int SPACE_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_in,
    input  logic       dash_in,
    input  logic       lg_in,
    input  logic       wg_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       err,
    output logic [2:0] sym_count
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT, EMIT_SPACE} state_t;
    state_t state;
    logic [4:0] code, ncode;
    logic [2:0] nlen;
    logic overflow, novf, last_space, space_pend, sym, conflict, gap;
    logic [7:0] letter;
    function automatic logic [7:0] lookup(input logic [2:0] l, input logic [4:0] c);
        case ({l, c})
            8'b001_00000: lookup = 8'h45;
            8'b001_00001: lookup = 8'h54;
            8'b010_00000: lookup = 8'h49;
            8'b010_00001: lookup = 8'h41;
            8'b010_00010: lookup = 8'h4E;
            8'b010_00011: lookup = 8'h4D;
            8'b011_00000: lookup = 8'h53;
            8'b011_00001: lookup = 8'h55;
            8'b011_00010: lookup = 8'h52;
            8'b011_00011: lookup = 8'h57;
            8'b011_00100: lookup = 8'h44;
            8'b011_00101: lookup = 8'h4B;
            8'b011_00110: lookup = 8'h47;
            8'b011_00111: lookup = 8'h4F;
            8'b100_00000: lookup = 8'h48;
            8'b100_00001: lookup = 8'h56;
            8'b100_00010: lookup = 8'h46;
            8'b100_00100: lookup = 8'h4C;
            8'b100_00110: lookup = 8'h50;
            8'b100_00111: lookup = 8'h4A;
            8'b100_01000: lookup = 8'h42;
            8'b100_01001: lookup = 8'h58;
            8'b100_01010: lookup = 8'h43;
            8'b100_01011: lookup = 8'h59;
            8'b100_01100: lookup = 8'h5A;
            8'b100_01101: lookup = 8'h51;
            8'b101_01111: lookup = 8'h31;
            8'b101_00111: lookup = 8'h32;
            8'b101_00011: lookup = 8'h33;
            8'b101_00001: lookup = 8'h34;
            8'b101_00000: lookup = 8'h35;
            8'b101_10000: lookup = 8'h36;
            8'b101_11000: lookup = 8'h37;
            8'b101_11100: lookup = 8'h38;
            8'b101_11110: lookup = 8'h39;
            8'b101_11111: lookup = 8'h30;
            default:      lookup = 8'h3F;
        endcase
    endfunction
    // Buffer as it stands after this cycle's symbol, so a same-cycle gap closes it.
    always_comb begin
        sym      = dot_in ^ dash_in;
        conflict = dot_in & dash_in;
        nlen     = (sym && sym_count < 3'd6) ? sym_count + 3'd1 : sym_count;
        ncode    = (sym && sym_count < 3'd5) ? {code[3:0], dash_in} : code;
        novf     = overflow | (sym && sym_count >= 3'd5);
        gap      = (state == IDLE || state == COLLECT) && (lg_in || wg_in);
        letter   = lookup(nlen, ncode);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            code       <= '0;
            sym_count  <= '0;
            overflow   <= 1'b0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            err        <= 1'b0;
            last_space <= 1'b1;
            space_pend <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            err        <= conflict;
            if (gap && nlen != 3'd0) begin
                char_valid <= 1'b1;
                char_out   <= letter;
                err        <= conflict | novf | (letter == 8'h3F);
                code       <= '0;
                sym_count  <= '0;
                overflow   <= 1'b0;
                last_space <= 1'b0;
                space_pend <= wg_in && SPACE_EN != 0;
                state      <= EMIT;
            end else if (gap && wg_in && SPACE_EN != 0 && !last_space) begin
                char_valid <= 1'b1;
                char_out   <= 8'h20;
                last_space <= 1'b1;
                state      <= EMIT_SPACE;
            end else if (state == EMIT && space_pend) begin
                char_valid <= 1'b1;
                char_out   <= 8'h20;
                last_space <= 1'b1;
                space_pend <= 1'b0;
                code       <= ncode;
                sym_count  <= nlen;
                overflow   <= novf;
                state      <= EMIT_SPACE;
            end else begin
                code       <= ncode;
                sym_count  <= nlen;
                overflow   <= novf;
                state      <= nlen != 3'd0 ? COLLECT : IDLE;
            end
        end
    end
endmodule
